data_memory_pipelined: RTL and testbench

//   Byte-addressed, parametrised data memory for the Memory stage. Successor to the single-cycle data memory.

---
 rtl/data_memory_pipelined.sv | 138 +++++++++++++
 tb/tb_data_memory_pipelined.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipelined.sv
// Byte-addressed data memory for the Memory stage. Requests use a valid/ready handshake,
// responses come out in order after READ_LATENCY cycles, and misaligned/out-of-range accesses are reported as faults.
module data_memory_pipelined #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  MEM_Control,
    input  logic [31:0] Addr,
    input  logic [31:0] W_Data,
    output logic        Resp_Valid,
    input  logic        Resp_Ready,
    output logic [31:0] Data_Out,
    output logic [1:0]  Fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    localparam logic [2:0] MEM_BYTE              = 3'b000;
    localparam logic [2:0] MEM_HALFWORD          = 3'b001;
    localparam logic [2:0] MEM_WORD              = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("data_memory_pipelined: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH_WORDS < 16 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_memory_pipelined: DEPTH_WORDS must be a power of two >= 16");
    end

    logic [7:0] mem [4][DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          misal;
    logic          oor;
    logic [1:0]    fault;
    logic          accept;
    logic          adv;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    logic [READ_LATENCY-1:0]       vld_pipe_d, vld_pipe_q;
    logic [READ_LATENCY-1:0][31:0] dat_pipe_d, dat_pipe_q;
    logic [READ_LATENCY-1:0][1:0]  flt_pipe_d, flt_pipe_q;

    // Decode, byte-enable generation and load extension all happen in the request cycle;
    // the array read is asynchronous so the registered result reflects the array at the acceptance edge.
    always_comb begin
        idx      = Addr[2 +: AW];
        lane     = Addr[1:0];
        oor      = {1'b0, Addr} >= LIMIT;
        misal    = 1'b0;
        be       = 4'b0000;
        wdat     = W_Data;
        rd_word  = {mem[3][idx], mem[2][idx], mem[1][idx], mem[0][idx]};
        rd_byte  = rd_word[8*lane +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'h0;
        unique case (MEM_Control)
            MEM_BYTE, MEM_BYTE_UNSIGNED: begin
                be       = 4'b0001 << lane;
                wdat     = {4{W_Data[7:0]}};
                load_val = (MEM_Control == MEM_BYTE) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            end
            MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: begin
                misal    = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdat     = {2{W_Data[15:0]}};
                load_val = (MEM_Control == MEM_HALFWORD) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            end
            MEM_WORD: begin
                misal    = |lane;
                be       = 4'b1111;
                load_val = rd_word;
            end
            default: misal = 1'b1;
        endcase
        fault = {oor, misal};
    end

    assign Req_Ready = !(Resp_Valid && !Resp_Ready);
    assign adv       = Req_Ready;
    assign accept    = Req_Valid && Req_Ready;
    assign wr_en     = accept && Req_Write && (fault == 2'b00);

    // Whole pipeline advances or freezes together; bubbles carry zero payload.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        dat_pipe_d = dat_pipe_q;
        flt_pipe_d = flt_pipe_q;
        if (adv) begin
            vld_pipe_d[0] = accept;
            dat_pipe_d[0] = (accept && !Req_Write && fault == 2'b00) ? load_val : 32'h0;
            flt_pipe_d[0] = accept ? fault : 2'b00;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                dat_pipe_d[i] = dat_pipe_q[i-1];
                flt_pipe_d[i] = flt_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
            flt_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
            flt_pipe_q <= flt_pipe_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem[l][idx] <= wdat[8*l +: 8];
            end
        end
    end

    assign Resp_Valid = vld_pipe_q[READ_LATENCY-1];
    assign Data_Out   = dat_pipe_q[READ_LATENCY-1];
    assign Fault      = flt_pipe_q[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Directed bench for data_memory_pipelined at READ_LATENCY=2: single-request vector table,
// then streamed sequences for RAW, backpressure and reset with requests in flight.
module tb_data_memory_pipelined;
    localparam int DW  = 1024;
    localparam int LAT = 2;

    localparam logic [2:0] C_LB  = 3'b000;
    localparam logic [2:0] C_LH  = 3'b001;
    localparam logic [2:0] C_LW  = 3'b010;
    localparam logic [2:0] C_LBU = 3'b100;
    localparam logic [2:0] C_LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  mem_control;
    logic [31:0] addr, w_data;
    logic        resp_valid, resp_ready;
    logic [31:0] data_out;
    logic [1:0]  fault;

    always #5 clk = ~clk;

    data_memory_pipelined #(.DEPTH_WORDS(DW), .READ_LATENCY(LAT)) dut (
        .CLK(clk), .RST(rst),
        .Req_Valid(req_valid), .Req_Ready(req_ready), .Req_Write(req_write),
        .MEM_Control(mem_control), .Addr(addr), .W_Data(w_data),
        .Resp_Valid(resp_valid), .Resp_Ready(resp_ready),
        .Data_Out(data_out), .Fault(fault)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  ctl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_fault;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sreq[$];
    logic [31:0] got_d[$];
    logic [1:0]  got_f[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic vec_t mk(input logic wr, input logic [2:0] ctl, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] ed,
                                input logic [1:0] ef, input string nm);
        vec_t v;
        v.wr = wr; v.ctl = ctl; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_fault = ef; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_write   = v.wr;
        mem_control = v.ctl;
        addr        = v.addr;
        w_data      = v.wdata;
    endtask

    // One isolated request: checks acceptance, exact latency, data and fault.
    task automatic do_req(input vec_t v);
        int cyc;
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        #1;
        chk({v.name, " req_ready"}, {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " latency"}, cyc, LAT);
        chk({v.name, " data"}, data_out, v.exp_data);
        chk({v.name, " fault"}, {30'h0, fault}, {30'h0, v.exp_fault});
    endtask

    // Back-to-back requests from sreq with Resp_Ready low for cycles st_lo..st_hi.
    task automatic run_stream(input string nm, input int st_lo, input int st_hi);
        int          idx = 0;
        int          cyc = 0;
        int          extra = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_d = 32'h0;
        got_d.delete();
        got_f.delete();
        while (got_d.size() < sreq.size() && cyc < 60) begin
            @(negedge clk);
            resp_ready = !(cyc >= st_lo && cyc <= st_hi);
            if (idx < sreq.size()) begin
                drive(sreq[idx]);
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (resp_valid && !resp_ready)
                chk({nm, " req_ready low in stall"}, {31'h0, req_ready}, 32'h0);
            if (prev_stall)
                chk({nm, " data held in stall"}, data_out, prev_d);
            prev_stall = resp_valid && !resp_ready;
            prev_d     = data_out;
            if (resp_valid && resp_ready) begin
                got_d.push_back(data_out);
                got_f.push_back(fault);
            end
            if (req_valid && req_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) extra++;
            @(negedge clk);
        end
        chk({nm, " response count"}, got_d.size(), sreq.size());
        chk({nm, " no extra responses"}, extra, 0);
        for (int k = 0; k < sreq.size() && k < got_d.size(); k++) begin
            chk({nm, " ", sreq[k].name, " data"}, got_d[k], sreq[k].exp_data);
            chk({nm, " ", sreq[k].name, " fault"}, {30'h0, got_f[k]}, {30'h0, sreq[k].exp_fault});
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; mem_control = C_LW;
        addr = 32'h0; w_data = 32'h0; resp_ready = 1'b1;

        // Reset: two cycles high
        repeat (2) @(negedge clk);
        chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset data_out", data_out, 32'h0);
        chk("reset fault", {30'h0, fault}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", {31'h0, req_ready}, 32'h1);

        vecs.push_back(mk(1, C_LW,  32'h0000_0000, 32'h0123_4567, 32'h0, 2'b00, "SW @0"));
        vecs.push_back(mk(1, C_LB,  32'h0000_0040, 32'h0000_0011, 32'h0, 2'b00, "SB @40"));
        vecs.push_back(mk(1, C_LB,  32'h0000_0041, 32'hFFFF_FF22, 32'h0, 2'b00, "SB @41"));
        vecs.push_back(mk(1, C_LB,  32'h0000_0042, 32'h0000_0033, 32'h0, 2'b00, "SB @42"));
        vecs.push_back(mk(1, C_LB,  32'h0000_0043, 32'h0000_0044, 32'h0, 2'b00, "SB @43"));
        vecs.push_back(mk(0, C_LW,  32'h0000_0040, 32'h0, 32'h4433_2211, 2'b00, "LW @40"));
        vecs.push_back(mk(0, C_LBU, 32'h0000_0043, 32'h0, 32'h0000_0044, 2'b00, "LBU @43"));
        vecs.push_back(mk(0, C_LHU, 32'h0000_0042, 32'h0, 32'h0000_4433, 2'b00, "LHU @42"));
        vecs.push_back(mk(1, C_LW,  32'h0000_0010, 32'h0000_0000, 32'h0, 2'b00, "SW @10"));
        vecs.push_back(mk(1, C_LH,  32'h0000_0012, 32'hABCD_8001, 32'h0, 2'b00, "SH @12"));
        vecs.push_back(mk(0, C_LH,  32'h0000_0012, 32'h0, 32'hFFFF_8001, 2'b00, "LH @12"));
        vecs.push_back(mk(0, C_LHU, 32'h0000_0012, 32'h0, 32'h0000_8001, 2'b00, "LHU @12"));
        vecs.push_back(mk(0, C_LB,  32'h0000_0013, 32'h0, 32'hFFFF_FF80, 2'b00, "LB @13"));
        vecs.push_back(mk(0, C_LW,  32'h0000_0010, 32'h0, 32'h8001_0000, 2'b00, "LW @10"));
        vecs.push_back(mk(0, C_LW,  32'h0000_0042, 32'h0, 32'h0, 2'b01, "LW @42 misaligned"));
        vecs.push_back(mk(1, C_LH,  32'h0000_0041, 32'h0000_FFFF, 32'h0, 2'b01, "SH @41 misaligned"));
        vecs.push_back(mk(1, 3'b111, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0, 2'b01, "store bad ctl"));
        vecs.push_back(mk(0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 2'b01, "load bad ctl"));
        vecs.push_back(mk(0, C_LW,  32'h0000_0040, 32'h0, 32'h4433_2211, 2'b00, "LW @40 unchanged"));
        vecs.push_back(mk(1, C_LW,  32'h0000_1000, 32'hCAFE_F00D, 32'h0, 2'b10, "SW @1000 oor"));
        vecs.push_back(mk(0, C_LW,  32'h0000_1000, 32'h0, 32'h0, 2'b10, "LW @1000 oor"));
        vecs.push_back(mk(0, C_LW,  32'h0000_1002, 32'h0, 32'h0, 2'b11, "LW @1002 both"));
        vecs.push_back(mk(0, C_LW,  32'h0000_0000, 32'h0, 32'h0123_4567, 2'b00, "LW @0 no alias write"));
        vecs.push_back(mk(1, C_LB,  32'h0000_0FFF, 32'h0000_00AB, 32'h0, 2'b00, "SB @FFF"));
        vecs.push_back(mk(0, C_LBU, 32'h0000_0FFF, 32'h0, 32'h0000_00AB, 2'b00, "LBU @FFF"));
        vecs.push_back(mk(0, C_LB,  32'h0000_0FFF, 32'h0, 32'hFFFF_FFAB, 2'b00, "LB @FFF"));
        foreach (vecs[i]) do_req(vecs[i]);

        // Store then load to the same word on consecutive cycles
        sreq.delete();
        sreq.push_back(mk(1, C_LW, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0, 2'b00, "SW @80"));
        sreq.push_back(mk(0, C_LW, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 2'b00, "LW @80"));
        run_stream("raw", 100, 100);

        // Four back-to-back loads with Resp_Ready low for three cycles mid-stream
        sreq.delete();
        sreq.push_back(mk(0, C_LW,  32'h0000_0040, 32'h0, 32'h4433_2211, 2'b00, "L0"));
        sreq.push_back(mk(0, C_LW,  32'h0000_0000, 32'h0, 32'h0123_4567, 2'b00, "L1"));
        sreq.push_back(mk(0, C_LW,  32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 2'b00, "L2"));
        sreq.push_back(mk(0, C_LHU, 32'h0000_0012, 32'h0, 32'h0000_8001, 2'b00, "L3"));
        run_stream("bp", 3, 5);

        // Reset with two loads in flight: nothing must be consumed afterwards
        @(negedge clk);
        resp_ready = 1'b0;
        drive(mk(0, C_LW, 32'h0000_0080, 32'h0, 32'h0, 2'b00, "x"));
        req_valid = 1'b1;
        @(negedge clk);
        drive(mk(0, C_LW, 32'h0000_0040, 32'h0, 32'h0, 2'b00, "x"));
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        chk("rst mid-op resp_valid", {31'h0, resp_valid}, 32'h0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst mid-op no responses", seen, 0);
        chk("rst mid-op req_ready", {31'h0, req_ready}, 32'h1);
        do_req(mk(0, C_LW, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 2'b00, "LW @80 after reset"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
